ntt_loop_ctrl: RTL and testbench

- Parametrised loop/issue controller for the multi-lane NTT/INTT/PWM datapath; generates (stage i, group s) addresses each cycle plus aligned bank read/write enables and a finish pulse.
- Generalises the earlier control FSM in:
  - transform size, lane count, radix and latencies;
  - an explicit IDLE/RUN/DRAIN state machine with opcode latched at start;
  - a stall input and a busy flag.
- Sits between the top-level command interface and the memory map / RBFU array.

---
 rtl/ntt_loop_ctrl_pkg.sv | 49 ++++
 rtl/ntt_loop_ctrl_delay.sv | 26 ++
 rtl/ntt_loop_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ntt_loop_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_loop_ctrl_pkg.sv
// Shared encodings and derived-constant helpers for the NTT loop/issue controller.
package ntt_loop_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NTT  = 2'b00,
    OP_PWM0 = 2'b01,
    OP_PWM1 = 2'b10,
    OP_INTT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Number of butterfly stages for the chosen radix.
  function automatic int f_stages(input int log_n, input int radix_log);
    return log_n / radix_log;
  endfunction

  // Butterflies per stage.
  function automatic int f_bf(input int log_n, input int radix_log);
    return (1 << log_n) >> radix_log;
  endfunction

  // Group base of the last issue within a stage.
  function automatic int f_s_end(input int log_n, input int radix_log, input int lanes);
    return f_bf(log_n, radix_log) - lanes;
  endfunction

  // Last group index of a point-wise multiply pass.
  function automatic int f_pwm_end(input int log_n, input int lanes);
    return (1 << log_n) / (2 * lanes) - 1;
  endfunction

  // Width of the stage counter, never below one bit.
  function automatic int f_i_w(input int log_n, input int radix_log);
    int st;
    st = f_stages(log_n, radix_log);
    return (st <= 1) ? 1 : $clog2(st);
  endfunction

  // Width of the group counter.
  function automatic int f_s_w(input int log_n);
    return log_n - 1;
  endfunction

endpackage

// File: rtl/ntt_loop_ctrl_delay.sv
// Fixed-latency shift line with synchronous active-low clear; DEPTH must be >= 1.
module sig_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift the input one tap per cycle; reset flushes every tap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_loop_ctrl.sv
// Loop/issue controller for the NTT/INTT/PWM datapath: walks (stage, group)
// addresses, delays issue into bank read/write enables and raises finish with
// the last write. Optional macro STAGE_RANGE_EN adds stage_lo/stage_hi inputs
// restricting which NTT/INTT stages run.
module ntt_loop_ctrl
  import ntt_loop_ctrl_pkg::*;
#(
  parameter  int LOG_N     = 8,
  parameter  int LANES     = 2,
  parameter  int RADIX_LOG = 1,
  parameter  int RD_LAT    = 2,
  parameter  int WR_LAT    = 10,
  localparam int I_W       = f_i_w(LOG_N, RADIX_LOG),
  localparam int S_W       = f_s_w(LOG_N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     opcode,
  input  logic           start,
  input  logic           stall,
`ifdef STAGE_RANGE_EN
  input  logic [I_W-1:0] stage_lo,
  input  logic [I_W-1:0] stage_hi,
`endif
  output logic [I_W-1:0] i,
  output logic [S_W-1:0] s,
  output logic           issue,
  output logic           ren,
  output logic           wen,
  output logic           en,
  output logic           busy,
  output logic           finish
);

  localparam int STAGES  = f_stages(LOG_N, RADIX_LOG);
  localparam int S_END   = f_s_end(LOG_N, RADIX_LOG, LANES);
  localparam int PWM_END = f_pwm_end(LOG_N, LANES);
  localparam int CNT_W   = $clog2(WR_LAT + 1);

  localparam logic [S_W-1:0]   S_END_V   = S_W'(S_END);
  localparam logic [S_W-1:0]   PWM_END_V = S_W'(PWM_END);
  localparam logic [I_W-1:0]   TOP_STAGE = I_W'(STAGES - 1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(WR_LAT - 1);

  state_e           state_q, state_d;
  op_e              mode_q, mode_d;
  logic [I_W-1:0]   i_q, i_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             issue_w, last_w;
  logic [I_W-1:0]   rng_lo, rng_hi, start_lo, start_hi;
  logic             rng_empty;
  op_e              op_in;
  logic             is_pwm, is_intt;
  logic [I_W-1:0]   last_stage;

`ifdef STAGE_RANGE_EN
  logic [I_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic           empty_q, empty_d;
  assign start_lo  = stage_lo;
  assign start_hi  = stage_hi;
  assign rng_lo    = lo_q;
  assign rng_hi    = hi_q;
  assign rng_empty = empty_q;
`else
  assign start_lo  = '0;
  assign start_hi  = TOP_STAGE;
  assign rng_lo    = '0;
  assign rng_hi    = TOP_STAGE;
  assign rng_empty = 1'b0;
`endif

  assign op_in      = op_e'(opcode);
  assign is_pwm     = (mode_q == OP_PWM0) || (mode_q == OP_PWM1);
  assign is_intt    = (mode_q == OP_INTT);
  assign last_stage = is_intt ? rng_lo : rng_hi;

  // State, mode, address counters and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= OP_NTT;
      i_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef STAGE_RANGE_EN
      lo_q    <= '0;
      hi_q    <= '0;
      empty_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`ifdef STAGE_RANGE_EN
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      empty_q <= empty_d;
`endif
    end
  end

  // Next state: accept start in IDLE, walk addresses in RUN, count down DRAIN.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    i_d     = i_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
`ifdef STAGE_RANGE_EN
    lo_d    = lo_q;
    hi_d    = hi_q;
    empty_d = empty_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = op_in;
          s_d     = '0;
          cnt_d   = '0;
          if (op_in == OP_INTT)     i_d = start_hi;
          else if (op_in == OP_NTT) i_d = start_lo;
          else                      i_d = '0;
`ifdef STAGE_RANGE_EN
          lo_d    = stage_lo;
          hi_d    = stage_hi;
          empty_d = (stage_lo > stage_hi) && ((op_in == OP_NTT) || (op_in == OP_INTT));
`endif
        end
      end
      ST_RUN: begin
        if (last_w) begin
          state_d = ST_DRAIN;
          i_d     = '0;
          s_d     = '0;
          cnt_d   = '0;
        end else if (issue_w) begin
          if (is_pwm) begin
            s_d = s_q + S_W'(1);
          end else if (s_q == S_END_V) begin
            s_d = '0;
            i_d = is_intt ? (i_q - I_W'(1)) : (i_q + I_W'(1));
          end else begin
            s_d = s_q + S_W'(LANES);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Issue and last-issue marker; an empty stage range emits only the marker.
  always_comb begin
    issue_w = 1'b0;
    last_w  = 1'b0;
    if (state_q == ST_RUN) begin
      if (rng_empty) begin
        last_w = 1'b1;
      end else if (!stall) begin
        issue_w = 1'b1;
        if (is_pwm) last_w = (s_q == PWM_END_V);
        else        last_w = (i_q == last_stage) && (s_q == S_END_V);
      end
    end
  end

  sig_delay #(.DEPTH(RD_LAT), .WIDTH(1)) u_ren_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (issue_w),
    .q_o   (ren)
  );

  sig_delay #(.DEPTH(WR_LAT), .WIDTH(1)) u_wen_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (issue_w),
    .q_o   (wen)
  );

  sig_delay #(.DEPTH(WR_LAT), .WIDTH(1)) u_fin_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (last_w),
    .q_o   (finish)
  );

  assign i     = i_q;
  assign s     = s_q;
  assign issue = issue_w;
  assign busy  = busy_q;
  assign en    = ren | wen;

endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Scoreboard bench for ntt_loop_ctrl at default parameters.
module tb_ntt_loop_ctrl;

  localparam int I_W = 3;
  localparam int S_W = 7;

  logic           clk = 1'b0;
  logic           rst_n, start, stall;
  logic [1:0]     opcode;
  logic [I_W-1:0] i;
  logic [S_W-1:0] s;
  logic           issue, ren, wen, en, busy, finish;

  ntt_loop_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .start  (start),
    .stall  (stall),
`ifdef STAGE_RANGE_EN
    .stage_lo (3'd0),
    .stage_hi (3'd7),
`endif
    .i      (i),
    .s      (s),
    .issue  (issue),
    .ren    (ren),
    .wen    (wen),
    .en     (en),
    .busy   (busy),
    .finish (finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int i;
    int s;
  } iss_t;

  iss_t q_iss[$];
  int   q_ren[$];
  int   q_wen[$];
  int   q_fin[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_fin = 0;
  int   last_fin = -1;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    iss_t e;
    int   c;
    if (mon_en) begin
      if (issue === 1'b1) begin
        if (q_iss.size() == 0) chk("issue_unexpected", cyc, -1);
        else begin
          e = q_iss.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("issue_i", int'(i), e.i);
          chk("issue_s", int'(s), e.s);
        end
      end
      if (ren === 1'b1) begin
        if (q_ren.size() == 0) chk("ren_unexpected", cyc, -1);
        else begin c = q_ren.pop_front(); chk("ren_cycle", cyc, c); end
      end
      if (wen === 1'b1) begin
        if (q_wen.size() == 0) chk("wen_unexpected", cyc, -1);
        else begin c = q_wen.pop_front(); chk("wen_cycle", cyc, c); end
      end
      if (finish === 1'b1) begin
        n_fin++;
        last_fin = cyc;
        if (q_fin.size() == 0) chk("finish_unexpected", cyc, -1);
        else begin c = q_fin.pop_front(); chk("finish_cycle", cyc, c); end
      end
      if ((ren | wen | en) === 1'b1) chk("en_or", int'(en), int'(ren | wen));
    end
  end

  // Push the expected issue/ren/wen/finish stream for one run starting at base.
  // Stall cycles [st_lo, st_hi] produce no issue; events past cut are dropped.
  task automatic push_expect(input int base, input logic [1:0] op,
                             input int st_lo, input int st_hi, input int cut);
    iss_t items[$];
    iss_t e;
    int   c;
    if (op == 2'b01 || op == 2'b10) begin
      for (int k = 0; k < 64; k++) begin
        e.cyc = 0; e.i = 0; e.s = k; items.push_back(e);
      end
    end else begin
      for (int st = 0; st < 8; st++)
        for (int g = 0; g < 128; g += 2) begin
          e.cyc = 0; e.i = (op == 2'b11) ? 7 - st : st; e.s = g; items.push_back(e);
        end
    end
    c = 1;
    for (int k = 0; k < items.size(); k++) begin
      while (c >= st_lo && c <= st_hi) c++;
      e = items[k];
      e.cyc = base + c;
      if (c <= cut)      q_iss.push_back(e);
      if (c + 2 <= cut)  q_ren.push_back(base + c + 2);
      if (c + 10 <= cut) q_wen.push_back(base + c + 10);
      if (k == items.size() - 1 && c + 10 <= cut) q_fin.push_back(base + c + 10);
      c++;
    end
  endtask

  // Drive one scenario for ncyc cycles; relative cycle 0 carries the start pulse.
  task automatic go(input string nm, input logic [1:0] op, input int ncyc,
                    input int st_lo, input int st_hi, input int xs1, input int xs2,
                    input int op_chg, input int rst_at, input int fin_rel, input int hold_s);
    int base;
    int fin0;
    base = cyc;
    fin0 = n_fin;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) tick();
      if (c == 1) chk({nm, "_busy_after_start"}, int'(busy), 1);
      if (c == fin_rel) chk({nm, "_busy_at_finish"}, int'(busy), 1);
      if (c == fin_rel + 1) chk({nm, "_busy_after_finish"}, int'(busy), 0);
      if (c >= st_lo && c <= st_hi) begin
        chk({nm, "_hold_i"}, int'(i), 0);
        chk({nm, "_hold_s"}, int'(s), hold_s);
      end
      if (rst_at > 0 && c == rst_at + 1)
        chk({nm, "_outputs_after_reset"},
            int'({issue, i, s, ren, wen, en, busy, finish}), 0);
      start = (c == 0) || (c == xs1) || (c == xs2);
      stall = (c >= st_lo) && (c <= st_hi);
      rst_n = (c != rst_at);
      if (c == 0) opcode = op;
      else if (c == op_chg) opcode = ~op;
    end
    start = 1'b0;
    stall = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    chk({nm, "_issues_left"}, q_iss.size(), 0);
    chk({nm, "_ren_left"}, q_ren.size(), 0);
    chk({nm, "_wen_left"}, q_wen.size(), 0);
    chk({nm, "_finish_count"}, n_fin - fin0, 1);
    chk({nm, "_finish_rel_cycle"}, last_fin - base, fin_rel);
    q_iss.delete(); q_ren.delete(); q_wen.delete(); q_fin.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stall  = 1'b0;
    opcode = 2'b00;
    repeat (3) tick();
    chk("reset_outputs", int'({issue, i, s, ren, wen, en, busy, finish}), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // NTT: 512 issues at cycles 1..512, finish at 522.
    push_expect(cyc, 2'b00, -1, -1, 1 << 30);
    go("ntt", 2'b00, 526, -1, -1, -1, -1, -1, -1, 522, 0);

    // INTT: stage 7 down to 0, finish at 522.
    push_expect(cyc, 2'b11, -1, -1, 1 << 30);
    go("intt", 2'b11, 526, -1, -1, -1, -1, -1, -1, 522, 0);

    // PWM1: 64 issues, finish at 74.
    push_expect(cyc, 2'b10, -1, -1, 1 << 30);
    go("pwm1", 2'b10, 78, -1, -1, -1, -1, -1, -1, 74, 0);

    // NTT with stall in cycles 10..14: counters hold at (0,18), finish at 527.
    push_expect(cyc, 2'b00, 10, 14, 1 << 30);
    go("stall", 2'b00, 531, 10, 14, -1, -1, -1, -1, 527, 18);

    // Extra starts at 100 and 522 plus opcode change at 50 must be ignored.
    push_expect(cyc, 2'b00, -1, -1, 1 << 30);
    go("ignore", 2'b00, 530, -1, -1, 100, 522, 50, -1, 522, 0);

    // Reset at cycle 200 aborts silently; restart at 205 finishes at 727.
    push_expect(cyc, 2'b00, -1, -1, 200);
    push_expect(cyc + 205, 2'b00, -1, -1, 1 << 30);
    go("reset", 2'b00, 731, -1, -1, 205, -1, -1, 200, 727, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
